// File: rtl/mem_access_unit.sv
// Sub-word load/store sequencer in front of a 32-bit word-addressed data memory.
// Sub-word stores are read-modify-write; misaligned or illegal requests never touch memory.
module mem_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        write_q, write_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [31:0] respRdata_q, respRdata_d;
  logic        respErr_q, respErr_d;

  logic        reqErr;
  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic [31:0] loadData;
  logic [31:0] mergeMask;
  logic [31:0] mergeRep;
  logic [31:0] mergedWord;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP) && !reset;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = memWdata_q;
  // The write already in WR completes on its edge even if reset is raised.
  assign mem_we     = (state_q == WR);

  assign reqErr = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                  (req_read == req_write);

  always_comb begin
    byteLane = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: byteLane = mem_rdata[7:0];
      2'd1: byteLane = mem_rdata[15:8];
      2'd2: byteLane = mem_rdata[23:16];
      2'd3: byteLane = mem_rdata[31:24];
      default: byteLane = mem_rdata[7:0];
    endcase
    halfLane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   loadData = {{24{signed_q & byteLane[7]}}, byteLane};
      2'b01:   loadData = {{16{signed_q & halfLane[15]}}, halfLane};
      default: loadData = mem_rdata;
    endcase
  end

  always_comb begin
    if (size_q == 2'b00) begin
      mergeMask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
      mergeRep  = {4{wdata_q[7:0]}};
    end else begin
      mergeMask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
      mergeRep  = {2{wdata_q}};
    end
    mergedWord = (mem_rdata & ~mergeMask) | (mergeRep & mergeMask);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    signed_d    = signed_q;
    write_d     = write_q;
    memWdata_d  = memWdata_q;
    respRdata_d = respRdata_q;
    respErr_d   = respErr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata[15:0];
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          if (reqErr) begin
            respErr_d   = 1'b1;
            respRdata_d = 32'h0;
            state_d     = RESP;
          end else if (req_write && (req_size == 2'b10)) begin
            memWdata_d = req_wdata;
            state_d    = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        if (write_q) begin
          memWdata_d = mergedWord;
          state_d    = WR;
        end else begin
          respRdata_d = loadData;
          respErr_d   = 1'b0;
          state_d     = RESP;
        end
      end
      WR: begin
        respRdata_d = 32'h0;
        respErr_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 16'h0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      memWdata_q  <= 32'h0;
      respRdata_q <= 32'h0;
      respErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      write_q     <= write_d;
      memWdata_q  <= memWdata_d;
      respRdata_q <= respRdata_d;
      respErr_q   <= respErr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a behavioural word memory plus scoreboards
// for responses and memory writes, each entry carrying its expected cycle.
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t respQ[$];
  exp_t writeQ[$];
  logic [31:0] mem [0:63];
  int total = 0;
  int bad = 0;
  int cycleCnt = 0;

  mem_access_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clock) begin
    if (mem_we === 1'b1) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  function automatic void checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  always @(negedge clock) begin
    if (respQ.size() > 0) checkOutput({respQ[0].tag, "_ready_busy"}, {31'b0, req_ready}, 32'h0);
    if (resp_valid === 1'b1) begin
      if (respQ.size() == 0) begin
        checkOutput("spurious_resp", {31'b0, resp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = respQ.pop_front();
        checkOutput({e.tag, "_rdata"}, resp_rdata, e.data);
        checkOutput({e.tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
        checkOutput({e.tag, "_resp_cycle"}, cycleCnt, e.cyc);
      end
    end
    if (mem_we === 1'b1) begin
      if (writeQ.size() == 0) begin
        checkOutput("spurious_mem_we", {31'b0, mem_we}, 32'h0);
      end else begin
        exp_t w;
        w = writeQ.pop_front();
        checkOutput({w.tag, "_wr_addr"}, mem_addr, w.addr);
        checkOutput({w.tag, "_wr_data"}, mem_wdata, w.data);
        checkOutput({w.tag, "_wr_cycle"}, cycleCnt, w.cyc);
      end
    end
  end

  task automatic waitReady(input string tag);
    int n = 0;
    @(negedge clock);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) checkOutput({tag, "_ready_timeout"}, {31'b0, req_ready}, 32'h1);
  endtask

  // rd/wr/size/signed/addr/wdata, then expected response and optional memory write.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] expR, input logic expE, input int lat,
                               input logic expWr, input logic [31:0] expWd, input int wrLat,
                               input bit hold);
    exp_t e;
    waitReady(tag);
    req_read   = rd;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clock);
    e.data = expR; e.addr = 32'h0; e.err = expE; e.cyc = cycleCnt + lat; e.tag = tag;
    respQ.push_back(e);
    if (expWr) begin
      e.data = expWd; e.addr = {addr[31:2], 2'b00}; e.err = 1'b0; e.cyc = cycleCnt + wrLat;
      writeQ.push_back(e);
    end
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((respQ.size() != 0 || writeQ.size() != 0) && n < 30) begin
      @(negedge clock);
      n++;
    end
    checkOutput("resp_queue_empty", respQ.size(), 32'h0);
    checkOutput("write_queue_empty", writeQ.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("rst_resp_err", {31'b0, resp_err}, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'h1);

    // Word store then load.
    applyStimulus("sw_10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF, 1, 0);
    applyStimulus("lw_10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0, 32'h0, 0, 0);

    // Byte/halfword loads from 0x80FF7F01.
    applyStimulus("sw_20", 0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 32'h0, 0, 2, 1, 32'h80FF7F01, 1, 0);
    applyStimulus("lb_23", 1, 0, 2'b00, 1, 32'h23, 32'h0, 32'hFFFFFF80, 0, 3, 0, 32'h0, 0, 0);
    applyStimulus("lbu_23", 1, 0, 2'b00, 0, 32'h23, 32'h0, 32'h00000080, 0, 3, 0, 32'h0, 0, 0);
    applyStimulus("lb_21", 1, 0, 2'b00, 1, 32'h21, 32'h0, 32'h0000007F, 0, 3, 0, 32'h0, 0, 0);
    applyStimulus("lbu_22", 1, 0, 2'b00, 0, 32'h22, 32'h0, 32'h000000FF, 0, 3, 0, 32'h0, 0, 0);
    applyStimulus("lh_22", 1, 0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF80FF, 0, 3, 0, 32'h0, 0, 0);
    applyStimulus("lhu_20", 1, 0, 2'b01, 0, 32'h20, 32'h0, 32'h00007F01, 0, 3, 0, 32'h0, 0, 0);
    applyStimulus("lw_20_sgn", 1, 0, 2'b10, 1, 32'h20, 32'h0, 32'h80FF7F01, 0, 3, 0, 32'h0, 0, 0);

    // Sub-word read-modify-write on 0x11223344; upper wdata bits must be ignored.
    applyStimulus("sw_30", 0, 1, 2'b10, 0, 32'h30, 32'h11223344, 32'h0, 0, 2, 1, 32'h11223344, 1, 0);
    applyStimulus("sb_31", 0, 1, 2'b00, 0, 32'h31, 32'h123456AB, 32'h0, 0, 4, 1, 32'h1122AB44, 3, 0);
    applyStimulus("sh_32", 0, 1, 2'b01, 0, 32'h32, 32'h5555BEEF, 32'h0, 0, 4, 1, 32'hBEEFAB44, 3, 0);
    applyStimulus("lw_30", 1, 0, 2'b10, 0, 32'h30, 32'h0, 32'hBEEFAB44, 0, 3, 0, 32'h0, 0, 0);

    // Error requests: response at T+1, no memory write.
    applyStimulus("err_lh_41", 1, 0, 2'b01, 1, 32'h41, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0, 0);
    applyStimulus("err_sw_42", 0, 1, 2'b10, 0, 32'h42, 32'h99999999, 32'h0, 1, 1, 0, 32'h0, 0, 0);
    applyStimulus("err_size3", 1, 0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0, 0);
    applyStimulus("err_rd_wr", 1, 1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 1, 1, 0, 32'h0, 0, 0);
    applyStimulus("err_none", 0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0, 0);
    drain();

    // Reset while a sub-word store sits in RD_WAIT: nothing written, no response.
    waitReady("rst_sb");
    req_read = 1'b0; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h00000077; req_valid = 1'b1;
    @(posedge clock); #1 req_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    checkOutput("rst_mid_mem_we", {31'b0, mem_we}, 32'h0);
    checkOutput("rst_mid_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_mid_ready_after", {31'b0, req_ready}, 32'h1);
    repeat (4) @(negedge clock);
    applyStimulus("lw_30_after_rst", 1, 0, 2'b10, 0, 32'h30, 32'h0, 32'hBEEFAB44, 0, 3, 0, 32'h0, 0, 0);
    drain();

    // Back-to-back stream with req_valid held high.
    applyStimulus("bb_sw_50", 0, 1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'hCAFEF00D, 1, 1);
    applyStimulus("bb_lw_50", 1, 0, 2'b10, 0, 32'h50, 32'h0, 32'hCAFEF00D, 0, 3, 0, 32'h0, 0, 1);
    applyStimulus("bb_sb_53", 0, 1, 2'b00, 0, 32'h53, 32'hFFFFFF12, 32'h0, 0, 4, 1, 32'h12FEF00D, 3, 1);
    applyStimulus("bb_lhu_52", 1, 0, 2'b01, 0, 32'h52, 32'h0, 32'h000012FE, 0, 3, 0, 32'h0, 0, 1);
    applyStimulus("bb_err_lh_51", 1, 0, 2'b01, 1, 32'h51, 32'h0, 32'h0, 1, 1, 0, 32'h0, 0, 1);
    applyStimulus("bb_lh_50", 1, 0, 2'b01, 1, 32'h50, 32'h0, 32'hFFFFF00D, 0, 3, 0, 32'h0, 0, 0);
    drain();
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sub-word load/store sequencer sitting directly upstream of the 32-bit word-addressed data memory. It accepts byte, halfword and word load/store requests from the CPU memory stage and converts them into word accesses on the memory port. Sub-word stores are done as read-modify-write. It returns sign- or zero-extended load data and flags misaligned or illegal requests without touching memory.

## Interface
- No parameters (data and address widths fixed at 32).
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; `(state==IDLE) && !reset`.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned or illegal request.
- mem_addr  out  32  word address to memory, `{addr_q[31:2],2'b00}`.
- mem_wdata  out  32  word to write.
- mem_we  out  1  write enable, one cycle per store.
- mem_rdata  in  32  memory read data, valid the cycle after mem_addr is presented with mem_we=0.

## Operation
- Request accepted when req_valid && req_ready; all req_* fields are registered at acceptance, and inputs are ignored outside IDLE.
- Error conditions, checked at acceptance: req_size==11; halfword with addr[0]=1; word with addr[1:0]!=0; req_read==req_write (both or neither).
- On error: no memory access (mem_we stays 0); resp_err=1 and resp_rdata=0.
- Byte lanes are little-endian:
  - Byte n occupies bits [8n+7:8n], with n=addr[1:0].
  - A halfword occupies [16h+15:16h], with h=addr[1].
- FSM states: IDLE, RD, RD_WAIT, WR, RESP.
  - IDLE -> RESP on an error request.
  - IDLE -> WR on a word store.
  - IDLE -> RD on a load or a sub-word store.
  - RD -> RD_WAIT unconditionally. mem_addr is presented in RD.
  - RD_WAIT captures mem_rdata at the end of the cycle. It then goes to RESP for a load, or to WR for a sub-word store.
  - WR: mem_we=1 for exactly this cycle, then -> RESP.
  - RESP: resp_valid=1, then -> IDLE.
- Load extraction: select the lane from the captured word.
  - Byte: extend bit 7 if req_signed, else zero-fill.
  - Halfword: extend bit 15 if req_signed, else zero-fill.
  - Word: pass through; req_signed is ignored.
- Store merge: `mem_wdata = (old & ~mask) | (rep & mask)`.
  - rep is wdata[7:0] replicated ×4 for a byte, or wdata[15:0] replicated ×2 for a halfword.
  - mask is 0xFF<<8n for a byte, or 0xFFFF<<16h for a halfword.
  - Word store: mem_wdata = req_wdata unmodified.
- mem_addr holds its registered value in every state. mem_we is 0 outside WR.

## Timing
- Acceptance happens at cycle T. resp_valid asserts at:
  - T+1 for an error request.
  - T+2 for a word store (mem_we at T+1).
  - T+3 for a load (address at T+1, data sampled at T+2).
  - T+4 for a sub-word store (read at T+1, capture at T+2, write at T+3).
- Back-to-back requests: req_ready returns to 1 in the cycle after RESP, so the next acceptance is no earlier than RESP+1.
- Reset values: state=IDLE; resp_valid=0; resp_err=0; resp_rdata=0; mem_addr=0; mem_wdata=0; mem_we=0. req_ready=0 while reset is high.
- Reset mid-operation:
  - The in-flight request is dropped; no resp_valid is issued for it.
  - If reset is high in RD or RD_WAIT, WR is never reached, so a partial RMW never writes.
  - If reset is high in WR, mem_we is still 1 in that cycle, because the write completes on that edge. State returns to IDLE.
- resp_rdata and resp_err hold their values until the next RESP; they are meaningful only while resp_valid=1.

## Test plan
- Word store then load:
  - Store addr 0x10, data 0xDEADBEEF -> mem_we pulse at T+1, mem_addr=0x10, resp at T+2.
  - Load word from 0x10 -> resp_rdata=0xDEADBEEF at T+3.
- Byte loads, with memory word 0x80FF7F01 at 0x20:
  - lb 0x23 -> 0xFFFFFF80.
  - lbu 0x23 -> 0x00000080.
  - lb 0x21 -> 0x0000007F.
  - lh 0x22 -> 0xFFFF80FF.
  - lhu 0x20 -> 0x00007F01.
- Sub-word store RMW, with memory 0x11223344 at 0x30:
  - sb 0x31, data 0xAB -> written 0x1122AB44 at T+3.
  - sh 0x32, data 0xBEEF -> written 0xBEEFAB44.
- Errors, each giving resp_err=1 at T+1 with no mem_we:
  - lh 0x41.
  - sw 0x42.
  - size=11.
  - read and write both asserted.
- Reset during a sub-word store: reset high in RD_WAIT -> mem_we never asserts, no resp_valid, memory word unchanged, req_ready=1 one cycle after reset falls.
- Back-to-back load/store stream with req_valid held high -> exactly one resp_valid per accepted request, and req_ready is low from acceptance through RESP.
